// File: rtl/tnn_vote_pkg.sv
// Shared constants and types for the whitewine TNN feature-voting stage.
// The comparator netlist fixes W; the derived widths follow N_FEAT.
package tnn_vote_pkg;

    localparam int W      = 3;
    localparam int N_FEAT = 11;
    localparam int ADDR_W = $clog2(N_FEAT);
    localparam int CNT_W  = $clog2(N_FEAT + 1);

    // A strict majority of the features must hit for a positive class.
    localparam logic [CNT_W-1:0] VOTE_TH_RST = CNT_W'(N_FEAT / 2 + 1);

    typedef enum logic {
        ACCUM = 1'b0,
        OUT   = 1'b1
    } vote_state_t;

endpackage

// File: rtl/tnn_vote_if.sv
// Config, feature-stream and result signals of tnn_vote_unit.
// The master drives config, features and result-ready; the slave is the vote unit.
interface tnn_vote_if;
    import tnn_vote_pkg::*;

    logic              cfg_we;
    logic [ADDR_W-1:0] cfg_addr;
    logic [W-1:0]      cfg_data;
    logic              cfg_vote_we;
    logic [CNT_W-1:0]  cfg_vote;

    logic              s_valid;
    logic              s_ready;
    logic [W-1:0]      s_data;
    logic              s_last;

    logic              m_valid;
    logic              m_ready;
    logic [CNT_W-1:0]  m_score;
    logic              m_class;
    logic              m_err;

    modport master (
        output cfg_we, cfg_addr, cfg_data, cfg_vote_we, cfg_vote,
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_score, m_class, m_err
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, cfg_vote_we, cfg_vote,
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_score, m_class, m_err
    );

endinterface

// File: rtl/cgp.sv
// Approximate 3-bit comparator from the TNN library netlist.
// Hit when a > b, or when a == b and a is odd.
module cgp (
    input  logic [2:0] input_a,
    input  logic [2:0] input_b,
    output logic       cgp_out
);

    logic eq2;
    logic eq1;
    logic gt2;
    logic gt1;

    assign eq2 = ~(input_a[2] ^ input_b[2]);
    assign eq1 = ~(input_a[1] ^ input_b[1]);
    assign gt2 = input_a[2] & ~input_b[2];
    assign gt1 = input_a[1] & ~input_b[1];

    // At bit 0 the ">" and "== with a[0]" terms collapse to a[0] alone.
    assign cgp_out = gt2 | (eq2 & gt1) | (eq2 & eq1 & input_a[0]);

endmodule

// File: rtl/tnn_vote_unit.sv
// Feature-voting stage: counts comparator hits over one sample against
// programmable thresholds and reports score, class and framing error.
module tnn_vote_unit
    import tnn_vote_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    tnn_vote_if.slave  bus
);

    vote_state_t       state;
    vote_state_t       next_state;

    logic [W-1:0]      thr [N_FEAT];
    logic [W-1:0]      thr_sel;
    logic [CNT_W-1:0]  vote_th;

    logic [ADDR_W-1:0] idx;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  score_next;
    logic              hit;
    logic              hs;
    logic              at_end;
    logic              close;

    logic [CNT_W-1:0]  score_q;
    logic              class_q;
    logic              err_q;

    // NOTE: thresholds live in flops, not RAM, because the whole file must
    // clear on reset; a resettable loop like this cannot map to a memory macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_FEAT; i++) thr[i] <= '0;
        end else if (bus.cfg_we && (bus.cfg_addr < ADDR_W'(N_FEAT))) begin
            thr[bus.cfg_addr] <= bus.cfg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                  vote_th <= VOTE_TH_RST;
        else if (bus.cfg_vote_we) vote_th <= bus.cfg_vote;
    end

    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    always_comb begin
        thr_sel = '0;
        if (idx < ADDR_W'(N_FEAT)) thr_sel = thr[idx];
    end

    // The read uses the registered file, so a same-cycle write is seen next cycle.
    cgp u_cgp (
        .input_a (bus.s_data),
        .input_b (thr_sel),
        .cgp_out (hit)
    );

    assign hs         = bus.s_valid && bus.s_ready;
    assign at_end     = (idx == ADDR_W'(N_FEAT - 1));
    assign close      = hs && (bus.s_last || at_end);
    assign score_next = cnt + CNT_W'(hit);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= ACCUM;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ACCUM: if (close) next_state = OUT;
            OUT:   if (bus.m_valid && bus.m_ready) next_state = ACCUM;
        endcase
    end

    always_comb begin
        bus.s_ready = 1'b0;
        bus.m_valid = 1'b0;
        unique case (state)
            ACCUM: bus.s_ready = 1'b1;
            OUT:   bus.m_valid = 1'b1;
        endcase
    end

    // Count never exceeds N_FEAT since the sample closes at the last index.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
            cnt <= '0;
        end else if (close) begin
            idx <= '0;
            cnt <= '0;
        end else if (hs) begin
            idx <= idx + ADDR_W'(1);
            cnt <= score_next;
        end
    end

    // Result is latched once at close and held through OUT; later vote
    // threshold writes do not disturb a pending class.
    always_ff @(posedge clk) begin
        if (rst) begin
            score_q <= '0;
            class_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (close) begin
            score_q <= score_next;
            class_q <= (score_next >= vote_th);
            err_q   <= (bus.s_last != at_end);
        end
    end

    assign bus.m_score = score_q;
    assign bus.m_class = class_q;
    assign bus.m_err   = err_q;

endmodule
